// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves freeze/flush/stall priority,
// holds a branch flush across a memory freeze, and keeps saturating performance counters.
module pipe_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             pipe_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic             err_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {ST_RUN, ST_FREEZE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pend_br;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_base;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_timeout;
    logic              w_freeze;
    logic              w_flush;
    logic              w_stall;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [CNT_W-1:0]  r_freeze_cnt;
    logic              r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A held branch is only serviced once the freeze lifts, so freeze outranks flush.
    always_comb begin
        w_freeze      = mem_req_i & ~dmem_ready_i;
        w_flush       = ~w_freeze & (branch_taken_i | r_pend_br);
        w_stall       = ~w_freeze & ~w_flush & load_use_i;
        w_state_nxt   = w_freeze ? ST_FREEZE : ST_RUN;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        pipe_write_o  = 1'b0;
        if (rst_i && !w_freeze) begin
            if (w_flush) begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                pipe_write_o  = 1'b1;
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
            end else if (w_stall) begin
                idex_bubble_o = 1'b1;
                pipe_write_o  = 1'b1;
            end else begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                pipe_write_o  = 1'b1;
            end
        end
    end

    // Consecutive-freeze count restarts whenever the previous cycle was not frozen.
    always_comb begin
        w_wait_base = (r_state == ST_FREEZE) ? r_wait_cnt : '0;
        w_timeout   = w_freeze && (w_wait_base == WAIT_MAX);
        w_wait_nxt  = '0;
        if (w_freeze) begin
            w_wait_nxt = (w_wait_base == WAIT_MAX) ? WAIT_MAX : w_wait_base + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pend_br    <= 1'b0;
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_freeze && branch_taken_i) begin
                r_pend_br <= 1'b1;
            end else if (w_flush) begin
                r_pend_br <= 1'b0;
            end
            if (w_stall && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_freeze && r_freeze_cnt != CNT_MAX) begin
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;
    assign freeze_cnt_o = r_freeze_cnt;
    assign err_o        = r_err;

endmodule
